apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
APB initiator (requester) that turns a simple valid/ready command interface into APB SETUP/ACCESS transfers toward slaves such as the UART register block. It is the opposite end of the APB slave interface: it drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and consumes PREADY/PRDATA/PSLVERR. It handles wait states, slave errors, misaligned requests and a programmable PREADY timeout. The result of each transfer comes back on a response channel.

Parameters:
TIMEOUT, 256, max ACCESS cycles to wait for PREADY; 0 disables the timeout.
CNT_W, 16, width of wait-state counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  system clock, all logic on the rising edge
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  32  byte address
cmd_wdata  input  32  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  output  32  read data (0 for writes or errors)
rsp_err  output  1  slave error, misalignment or timeout
rsp_timeout  output  1  error caused by timeout
busy  output  1  high in any state other than IDLE
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  32  APB address
PWDATA  output  32  APB write data
PREADY  input  1  slave ready
PRDATA  input  32  slave read data
PSLVERR  input  1  slave error

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; all outputs 0 except cmd_ready=1; wait counter=0.
- Reset mid-transfer drops PSEL/PENABLE in the same cycle and discards any pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1; PSEL=PENABLE=0.
  - On acceptance, latch write/addr/wdata. If cmd_addr[1:0]==0, go to SETUP.
  - Otherwise skip APB entirely and go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; next state ACCESS; counter cleared.
- ACCESS: PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stay stable for the whole transfer.
  - PREADY=1: capture rsp_err=PSLVERR. rsp_rdata=PRDATA only for a read with PSLVERR=0, else 0. Go to RESP.
  - PREADY=0: increment counter. If TIMEOUT!=0 and counter==TIMEOUT-1, go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY wins over timeout when both occur in the same cycle.
- RESP:
  - PSEL=PENABLE=0; rsp_valid=1; rsp_* held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE. rsp_valid deasserts the next cycle; rsp_* may keep stale values.
- cmd_ready is 0 outside IDLE, so only one outstanding transfer exists. Minimum command-to-command spacing is 4 cycles: IDLE, SETUP, ACCESS, RESP with rsp_ready tied high.
- Latency: accept at edge 0 -> SETUP in cycle 1 -> ACCESS in cycle 2 -> with zero wait states rsp_valid=1 in cycle 3. Each PREADY-low cycle adds 1.
- PADDR/PWDATA return to 0 in IDLE and RESP. PWRITE=0 outside SETUP/ACCESS.
- The counter saturates and never wraps. When TIMEOUT=0 the master waits indefinitely.
- Commands presented while busy are ignored (not accepted) and must be held by the source.

Test Plan:
- Zero-wait write: addr=0x0000_0010, wdata=0xA5 with PREADY=1 -> PSEL high cycles 1-2, PENABLE high cycle 2 only; rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0.
- Wait-state read: addr=0x0000_001C with PREADY low 3 cycles and PRDATA=0x0000_0042 -> ACCESS lasts 4 cycles with PADDR stable; rsp_rdata=0x42; rsp_valid in cycle 6.
- Slave error: read with PREADY=1, PSLVERR=1, PRDATA=0xFFFF_FFFF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT=8, PREADY stuck low -> exactly 8 ACCESS cycles, then PSEL drops; rsp_err=1, rsp_timeout=1; a following command completes normally.
- Misaligned request: addr=0x0000_0013 -> PSEL never asserted; rsp_valid the cycle after acceptance with rsp_err=1.
- Backpressure/reset: rsp_ready held low 5 cycles -> rsp_* stable and cmd_ready=0 throughout. Then rst pulsed during ACCESS -> PSEL=PENABLE=0 immediately, rsp_valid=0, cmd_ready=1 after reset release.

Source files
------------

// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready command into one APB SETUP/ACCESS transfer
// and returns the outcome on a valid/ready response channel.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   cmd_*           command channel (valid/ready, write, addr, wdata)
//   rsp_*           response channel (valid/ready, rdata, err, timeout)
//   busy            high whenever the master is not idle
//   PSEL..PWDATA    APB request signals driven to the slave
//   PREADY..PSLVERR APB completion signals from the slave
//
// Misaligned commands (addr[1:0] != 0) never reach the bus and return an error.
// While PREADY is low the wait counter counts ACCESS cycles; reaching TIMEOUT
// ends the transfer with a timeout error (TIMEOUT = 0 waits forever).
module apb_master #(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        busy,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic        PREADY,
    input  logic [31:0] PRDATA,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    localparam logic             TmoEn   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    if (cmd_addr[1:0] == 2'b00) begin
                        state_d = StSetup;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        tmo_d   = 1'b0;
                        rdata_d = '0;
                    end
                end
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = '0;
            end
            StAccess: begin
                if (PREADY) begin
                    // PREADY takes priority over a timeout in the same cycle
                    state_d = StResp;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                    rdata_d = (!write_q && !PSLVERR) ? PRDATA : '0;
                end else begin
                    if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (TmoEn && (cnt_q == TmoLast)) begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        PWRITE      = 1'b0;
        PADDR       = '0;
        PWDATA      = '0;
        rsp_rdata   = rdata_q;
        rsp_err     = err_q;
        rsp_timeout = tmo_q;
        busy        = (state_q != StIdle);
        unique case (state_q)
            StIdle: cmd_ready = 1'b1;
            StSetup: begin
                PSEL   = 1'b1;
                PWRITE = write_q;
                PADDR  = addr_q;
                PWDATA = wdata_q;
            end
            StAccess: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PWRITE  = write_q;
                PADDR   = addr_q;
                PWDATA  = wdata_q;
            end
            StResp: rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, busy;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apb_master #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLVERR    (PSLVERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One command through the master. The slave holds PREADY low for 'waits'
    // ACCESS cycles; the response is back-pressured for 'bp' cycles.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int unsigned waits, input logic slverr,
                           input logic [31:0] rdata, input int unsigned bp);
        int unsigned exp_setup, exp_acc, exp_lat;
        logic        exp_err, exp_tmo;
        logic [31:0] exp_rd;
        int unsigned setup_n, acc_n, lat, hold, cycle;
        int unsigned bus_bad, idle_bad, stab_bad;
        logic        got, done;
        logic [31:0] cap_rd;
        logic        cap_err, cap_tmo;

        // Expected outcome from the transfer rules
        if (addr[1:0] != 2'b00) begin
            exp_setup = 0; exp_acc = 0; exp_lat = 1;
            exp_err = 1'b1; exp_tmo = 1'b0; exp_rd = '0;
        end else if (waits >= TMO) begin
            exp_setup = 1; exp_acc = TMO; exp_lat = 2 + TMO;
            exp_err = 1'b1; exp_tmo = 1'b1; exp_rd = '0;
        end else begin
            exp_setup = 1; exp_acc = waits + 1; exp_lat = 3 + waits;
            exp_err = slverr; exp_tmo = 1'b0;
            exp_rd = (!wr && !slverr) ? rdata : 32'h0;
        end

        @(negedge clk);
        check("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        rsp_ready = 1'b0;
        @(posedge clk);

        setup_n = 0; acc_n = 0; lat = 0; hold = 0; cycle = 0;
        bus_bad = 0; idle_bad = 0; stab_bad = 0;
        got = 1'b0; done = 1'b0; cap_rd = '0; cap_err = 1'b0; cap_tmo = 1'b0;
        while (!done && cycle < 200) begin
            @(negedge clk);
            cycle++;
            if (cycle == 1) begin
                cmd_valid = 1'b0;
                cmd_addr  = $urandom;
                cmd_wdata = $urandom;
            end
            if (!busy || cmd_ready) stab_bad++;
            if (PSEL && !PENABLE) begin
                setup_n++;
                if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) bus_bad++;
                PREADY = 1'b0;
            end else if (PSEL && PENABLE) begin
                acc_n++;
                if (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata) bus_bad++;
                PREADY  = (acc_n > waits);
                PSLVERR = slverr;
                PRDATA  = rdata;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = $urandom_range(0, 1);
                PRDATA  = $urandom;
                if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0 || PENABLE !== 1'b0)
                    idle_bad++;
            end
            if (rsp_valid) begin
                if (!got) begin
                    got = 1'b1; lat = cycle;
                    cap_rd = rsp_rdata; cap_err = rsp_err; cap_tmo = rsp_timeout;
                end else if (rsp_rdata !== cap_rd || rsp_err !== cap_err ||
                             rsp_timeout !== cap_tmo) begin
                    stab_bad++;
                end
                if (hold >= bp) begin
                    rsp_ready = 1'b1;
                    done = 1'b1;
                end else begin
                    hold++;
                    rsp_ready = 1'b0;
                end
            end
        end
        check("rsp_within_budget", {31'b0, done}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
        check("back_to_idle", {30'b0, cmd_ready, busy}, 32'd2);

        check("setup_cycles", setup_n, exp_setup);
        check("access_cycles", acc_n, exp_acc);
        check("rsp_latency", lat, exp_lat);
        check("rsp_rdata", cap_rd, exp_rd);
        check("rsp_err", {31'b0, cap_err}, {31'b0, exp_err});
        check("rsp_timeout", {31'b0, cap_tmo}, {31'b0, exp_tmo});
        check("bus_stable", bus_bad, 0);
        check("bus_idle_zero", idle_bad, 0);
        check("rsp_hold_busy", stab_bad, 0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
        #12;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_ctrl", {26'b0, rsp_valid, rsp_err, rsp_timeout, busy, PSEL, PENABLE}, 32'd0);
        check("rst_bus", PADDR | PWDATA | rsp_rdata | {31'b0, PWRITE}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_txn(1'b1, 32'h0000_0010, 32'h0000_00A5, 0, 1'b0, 32'h1234_5678, 0);
        run_txn(1'b0, 32'h0000_001C, 32'h0,         3, 1'b0, 32'h0000_0042, 0);
        run_txn(1'b0, 32'h0000_0020, 32'h0,         0, 1'b1, 32'hFFFF_FFFF, 0);
        run_txn(1'b0, 32'h0000_0024, 32'h0,        20, 1'b0, 32'h0000_0077, 0);
        run_txn(1'b0, 32'h0000_0028, 32'h0,         0, 1'b0, 32'h0000_0099, 0);
        run_txn(1'b0, 32'h0000_002C, 32'h0,         7, 1'b0, 32'hCAFE_0007, 0);
        run_txn(1'b1, 32'h0000_0030, 32'h0000_0008, 8, 1'b0, 32'h0,         0);
        run_txn(1'b0, 32'h0000_0013, 32'h0,         0, 1'b0, 32'h5555_5555, 0);
        run_txn(1'b0, 32'h0000_0040, 32'h0,         1, 1'b0, 32'hDEAD_BEEF, 5);

        // Reset in the middle of ACCESS
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0050; cmd_wdata = '0;
        PREADY = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_access", {30'b0, PSEL, PENABLE}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("rst_drops_bus", {29'b0, PSEL, PENABLE, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {30'b0, cmd_ready, busy}, 32'd2);
        run_txn(1'b1, 32'h0000_0060, 32'h0BAD_F00D, 2, 1'b0, 32'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            run_txn($urandom_range(0, 1), a, $urandom, $urandom_range(0, 11),
                    ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
